gate_truth_table_engine: RTL and testbench

Parametrised, clocked successor to the two-input gate blocks. It holds one selectable WIDTH-input reduction gate and, on command, steps through all 2^WIDTH input combinations. Each row is presented over a valid/ready stream and the engine reports a count of true outputs at completion. It serves as an on-chip truth-table generator and self-checker for the basic logic gate library.

---
 rtl/gate_truth_table_engine.sv | 132 +++++++++++++
 tb/tb_gate_truth_table_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_engine.sv
// rtl/gate_truth_table_engine.sv - sweeps all 2^WIDTH rows of a selectable reduction gate over a valid/ready stream
// and counts how many rows come out true.
module gate_truth_table_engine #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_row,
  output logic             out_y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   ones_count,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ROW_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ROW_ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   CNT_ONE  = (WIDTH + 1)'(1);

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   row_q, row_d;
  logic [WIDTH:0]     cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               y_q, y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  function automatic logic gate_eval(input logic [2:0] sel, input logic [WIDTH-1:0] row);
    case (sel)
      3'd0:    gate_eval = &row;
      3'd1:    gate_eval = |row;
      3'd2:    gate_eval = ^row;
      3'd3:    gate_eval = ~&row;
      3'd4:    gate_eval = ~|row;
      3'd5:    gate_eval = ~^row;
      default: gate_eval = 1'b0;
    endcase
  endfunction

  // The row register doubles as the sweep counter; it is never wrapped.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op <= 3'd5) begin
            op_d    = op;
            row_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b1;
            y_d     = gate_eval(op, '0);
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (valid_q && out_ready) begin
          if (y_q) cnt_d = cnt_q + CNT_ONE;
          if (row_q == ROW_LAST) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            row_d = row_q + ROW_ONE;
            y_d   = gate_eval(op_q, row_q + ROW_ONE);
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_row    = row_q;
  assign out_y      = y_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ones_count = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gate_truth_table_engine.sv
// tb/tb_gate_truth_table_engine.sv - scoreboard bench driving WIDTH=2 and WIDTH=4 engines with shared stimulus
module tb_gate_truth_table_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic       out_ready = 1'b1;

  logic       v2, y2, b2, d2, e2;
  logic [1:0] r2;
  logic [2:0] c2;
  logic       v4, y4, b4, d4, e4;
  logic [3:0] r4;
  logic [4:0] c4;

  gate_truth_table_engine #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .out_ready(out_ready),
    .out_valid(v2), .out_row(r2), .out_y(y2), .busy(b2), .done(d2),
    .ones_count(c2), .err(e2)
  );

  gate_truth_table_engine #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .out_ready(out_ready),
    .out_valid(v4), .out_row(r4), .out_y(y4), .busy(b4), .done(d4),
    .ones_count(c4), .err(e4)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_mode = 0;
  int start_cyc = 0;
  int dn2 = 0, dn4 = 0, done2_cyc = 0, done4_cyc = 0;
  int q2[$], q4[$], n2[$], n4[$];

  always @(posedge clk) cyc <= cyc + 1;

  // 0: always ready, 1: toggling, 2: random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Gate value from the number of set bits in the row.
  function automatic int model_y(input int opv, input int row, input int w);
    int n = 0;
    for (int i = 0; i < w; i++) n += (row >> i) & 1;
    case (opv)
      0: return (n == w) ? 1 : 0;
      1: return (n > 0) ? 1 : 0;
      2: return n % 2;
      3: return (n == w) ? 0 : 1;
      4: return (n > 0) ? 0 : 1;
      default: return 1 - (n % 2);
    endcase
  endfunction

  function automatic int closed_count(input int opv, input int w);
    case (opv)
      0, 4: return 1;
      1, 3: return (1 << w) - 1;
      default: return 1 << (w - 1);
    endcase
  endfunction

  task automatic push_sweep(input int opv);
    int s = 0;
    for (int r = 0; r < 4; r++) begin
      q2.push_back((r << 1) | model_y(opv, r, 2));
      s += model_y(opv, r, 2);
    end
    n2.push_back(s);
    s = 0;
    for (int r = 0; r < 16; r++) begin
      q4.push_back((r << 1) | model_y(opv, r, 4));
      s += model_y(opv, r, 4);
    end
    n4.push_back(s);
  endtask

  logic stall2 = 1'b0, stall4 = 1'b0;
  int   srow2, sy2, srow4, sy4;

  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      stall2 = 1'b0;
    end else begin
      if (stall2) begin
        check("w2 stall valid", v2, 1);
        check("w2 stall row", r2, srow2);
        check("w2 stall y", y2, sy2);
      end
      stall2 = v2 && !out_ready;
      srow2 = r2;
      sy2 = y2;
      if (v2 && out_ready) begin
        check("w2 row queued", q2.size() > 0, 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          check("w2 row", r2, e >> 1);
          check("w2 y", y2, e & 1);
        end
      end
      if (d2) begin
        dn2++;
        done2_cyc = cyc;
        check("w2 done expected", n2.size() > 0, 1);
        if (n2.size() > 0) check("w2 ones_count", c2, n2.pop_front());
        check("w2 rows left at done", q2.size(), 0);
        check("w2 busy at done", b2, 1);
        check("w2 valid at done", v2, 0);
      end
    end
  end

  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      stall4 = 1'b0;
    end else begin
      if (stall4) begin
        check("w4 stall valid", v4, 1);
        check("w4 stall row", r4, srow4);
        check("w4 stall y", y4, sy4);
      end
      stall4 = v4 && !out_ready;
      srow4 = r4;
      sy4 = y4;
      if (v4 && out_ready) begin
        check("w4 row queued", q4.size() > 0, 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          check("w4 row", r4, e >> 1);
          check("w4 y", y4, e & 1);
        end
      end
      if (d4) begin
        dn4++;
        done4_cyc = cyc;
        check("w4 done expected", n4.size() > 0, 1);
        if (n4.size() > 0) check("w4 ones_count", c4, n4.pop_front());
        check("w4 rows left at done", q4.size(), 0);
        check("w4 busy at done", b4, 1);
        check("w4 valid at done", v4, 0);
      end
    end
  end

  task automatic do_start(input int opv);
    @(posedge clk);
    #1;
    start = 1'b1;
    op = 3'(opv);
    @(posedge clk);
    #2;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!b2 && !b4 && !v2 && !v4) break;
    end
    check("idle reached within budget", k < 1000, 1);
  endtask

  task automatic sweep(input int opv, input int mode);
    int d2b = dn2, d4b = dn4;
    ready_mode = mode;
    push_sweep(opv);
    do_start(opv);
    wait_idle();
    check("w2 one done per sweep", dn2, d2b + 1);
    check("w4 one done per sweep", dn4, d4b + 1);
    check("w2 held count", c2, closed_count(opv, 2));
    check("w4 held count", c4, closed_count(opv, 4));
    if (mode == 0) begin
      check("w2 done latency", done2_cyc - start_cyc, 4);
      check("w4 done latency", done4_cyc - start_cyc, 16);
    end
  endtask

  task automatic illegal(input int opv);
    int h2 = c2, h4 = c4;
    do_start(opv);
    @(negedge clk);
    check("w2 err pulse", e2, 1);
    check("w4 err pulse", e4, 1);
    check("w2 busy after err", b2, 0);
    check("w2 valid after err", v2, 0);
    check("w2 count kept on err", c2, h2);
    check("w4 count kept on err", c4, h4);
    @(negedge clk);
    check("w2 err one cycle", e2, 0);
    check("w4 err one cycle", e4, 0);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  initial begin
    int k, d2b, d4b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset valid", {v2, v4}, 0);
    check("reset busy", {b2, b4}, 0);
    check("reset done err", {d2, d4, e2, e4}, 0);
    check("reset rows", {r2, r4}, 0);
    check("reset y", {y2, y4}, 0);
    check("reset counts", {c2, c4}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    sweep(1, 0);
    sweep(2, 1);
    illegal(6);
    illegal(7);

    // Start with a different op mid-sweep must be ignored.
    ready_mode = 0;
    d2b = dn2;
    d4b = dn4;
    push_sweep(0);
    do_start(0);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v2 && r2 == 2'd0) break;
    end
    @(posedge clk);
    #1 start = 1'b1;
    op = 3'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    check("ignored start w2 done once", dn2, d2b + 1);
    check("ignored start w4 done once", dn4, d4b + 1);
    check("ignored start w2 count", c2, 1);

    // Reset while the WIDTH=2 engine presents row 10.
    push_sweep(0);
    do_start(0);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v2 && r2 == 2'd2) break;
    end
    check("reached row 10", k < 20, 1);
    d2b = dn2;
    d4b = dn4;
    @(posedge clk);
    #1 rst_n = 1'b0;
    q2.delete();
    q4.delete();
    n2.delete();
    n4.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort valid", {v2, v4}, 0);
    check("abort busy", {b2, b4}, 0);
    check("abort counts", {c2, c4}, 0);
    repeat (3) @(negedge clk);
    check("abort no done w2", dn2, d2b);
    check("abort no done w4", dn4, d4b);
    sweep(4, 0);

    sweep(3, 0);
    sweep(5, 2);
    for (int i = 0; i < 6; i++) sweep($urandom_range(0, 5), $urandom_range(0, 2));
    ready_mode = 2;
    illegal($urandom_range(6, 7));
    sweep($urandom_range(0, 5), 2);

    repeat (3) @(negedge clk);
    check("w2 queue drained", q2.size() + n2.size(), 0);
    check("w4 queue drained", q4.size() + n4.size(), 0);
    summary();
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL timeout: simulation did not finish within time limit");
    summary();
    $finish;
  end

endmodule
